alu_pipelined: RTL and testbench
================================

Name: alu_pipelined

Overview:
- Parametrised, handshaked successor of the single-cycle combinational ALU in the Monociclo datapath, intended for the multicycle/pipelined CPU.
- Registers every result and adds status flags and an iterative shift-add multiplier (MUL/MULHU).
- Uses valid/ready on input and output.
- Keeps the existing 4-bit opcode encoding so the decoder is reused unchanged.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 8 and a power of two.
- SHAMT_W, $clog2(WIDTH), derived; number of operandB bits used as the shift amount.

Ports:
- clk  in  1  clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- inValid  in  1  operands and operation are valid.
- inReady  out  1  block accepts this cycle; a transfer occurs when inValid and inReady are both high.
- operandA  in  WIDTH  first operand.
- operandB  in  WIDTH  second operand / shift amount.
- operation  in  4  opcode.
- outValid  out  1  result and flags are valid.
- outReady  in  1  consumer accepts; a transfer occurs when outValid and outReady are both high.
- result  out  WIDTH  registered result.
- zeroFlag  out  1  result == 0.
- negativeFlag  out  1  result[WIDTH-1].
- carryFlag  out  1  ADD: carry out. SUB: borrow (A < B unsigned). 0 for all other ops.
- overflowFlag  out  1  ADD/SUB signed overflow; 0 for all other ops.
- busy  out  1  multiplier is iterating.

Behaviour:
- Reset (async on rstN low): state=IDLE; outValid=0; result=0; all flags=0; busy=0; iteration counter=0.
- Opcodes:
  - 0000 ADD; 1000 SUB; 0111 AND; 0110 OR; 0100 XOR.
  - 0001 SLL; 0101 SRL; 1101 SRA (true arithmetic, sign-filled); 0010 SLA (same as SLL).
  - 0011 SLT (signed, result 0/1); 1011 SLTU (unsigned, 0/1).
  - 1010 MUL (low WIDTH bits of the unsigned product); 1001 MULHU (high WIDTH bits of the unsigned product).
  - Any other opcode: pass operandA through.
- Shifts use only operandB[SHAMT_W-1:0]; upper bits are ignored.
- Arithmetic is modulo 2^WIDTH.
- States:
  - IDLE: no multiply in progress.
  - MULRUN: multiply iterating.
- inReady = (state==IDLE) && (!outValid || outReady). One output register, no skid buffer.
- Single-cycle ops: accept at edge N; result, flags and outValid=1 are visible after edge N. Latency is 1 cycle. Back-to-back throughput is 1 op/cycle while outReady=1.
- MUL/MULHU:
  - Accept at edge N: latch A and B; accumulator=0; counter=WIDTH-1; state=MULRUN; busy=1.
  - One shift-add step per edge.
  - At the step where counter==0: write result (low or high half), flags, outValid=1; state=IDLE; busy=0.
  - Total latency is WIDTH cycles from acceptance to outValid.
- outValid stays high and result/flags stay stable until an output transfer occurs.
- If outValid && !outReady: inReady=0 and a new input is not accepted.
- A transfer out with no new transfer in clears outValid on the same edge.
- Simultaneous output transfer and input accept of a single-cycle op: new result loads and outValid stays 1.
- During MULRUN the output register may still be draining the previous result; the multiply completion writes only when the output register is free (outValid=0, or outValid with outReady). Otherwise the final step stalls with counter held at 0.
- Operand inputs are ignored while not accepting; a multiply operates only on the latched copies.
- rstN asserted mid-multiply aborts immediately to reset values; no partial result is ever presented.

Decomposition:
- Package alu_pkg: opcode enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLA, SLT, SLTU, MUL, MULHU) with the 4-bit encodings above; state enum {IDLE, MULRUN}.
- Sub-module mul_iterative: WIDTH-parameterised shift-add unit with start, done and 2*WIDTH product.
- Top-level holds the combinational op mux, flag logic, output register and handshake.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 -> result 0x80000000, overflowFlag=1, negativeFlag=1, carryFlag=0, 1-cycle latency. ADD 0xFFFFFFFF+1 -> result 0, zeroFlag=1, carryFlag=1.
- SUB 3-5 -> 0xFFFFFFFE, carryFlag(borrow)=1. SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
- MUL 0x00010000 x 0x00010000 -> result 0, zeroFlag=1, outValid exactly 32 cycles after accept, busy high throughout, inReady low throughout. MULHU same operands -> 0x00000001.
- Backpressure: hold outReady=0 for 5 cycles after an ADD -> result stable, inReady=0; then outReady=1 with a queued XOR -> XOR result on the next cycle, no op lost or duplicated.
- Streaming: 8 random single-cycle ops with outReady=1 -> 8 results on consecutive cycles, each matching the golden model.
- Assert rstN low at multiply cycle 10 -> outValid=0 and result=0 immediately; after release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings shared by the pipelined ALU
package alu_pkg;
  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    SUB   = 4'b1000,
    AND   = 4'b0111,
    OR    = 4'b0110,
    XOR   = 4'b0100,
    SLL   = 4'b0001,
    SRL   = 4'b0101,
    SRA   = 4'b1101,
    SLA   = 4'b0010,
    SLT   = 4'b0011,
    SLTU  = 4'b1011,
    MUL   = 4'b1010,
    MULHU = 4'b1001
  } opcode_e;
  typedef enum logic {IDLE, MULRUN} state_e;
endpackage

// File: rtl/alu_pipelined_if.sv
// alu_pipelined_if: valid/ready operand and result bus of the pipelined ALU
interface alu_pipelined_if #(parameter int WIDTH = 32);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [3:0]       operation;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zeroFlag;
  logic             negativeFlag;
  logic             carryFlag;
  logic             overflowFlag;
  logic             busy;
  modport master (
    output inValid, operandA, operandB, operation, outReady,
    input  inReady, outValid, result, zeroFlag, negativeFlag, carryFlag, overflowFlag, busy
  );
  modport slave (
    input  inValid, operandA, operandB, operation, outReady,
    output inReady, outValid, result, zeroFlag, negativeFlag, carryFlag, overflowFlag, busy
  );
endinterface

// File: rtl/mul_iterative.sv
// mul_iterative: radix-2 shift-add unsigned multiplier, one step per enabled edge
module mul_iterative #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;
  // add multiplicand into the upper half when the current multiplier bit is set
  always_comb sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  // product is the partial product after the pending step, so it is final while done
  assign product = {sum, p_q[WIDTH-1:1]};
  assign done = cnt_q == '0;
  // latch operands on start, then shift right one bit per step; counter parks at 0
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      a_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= a;
      p_q   <= {{WIDTH{1'b0}}, b};
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      p_q <= product;
      if (!done) cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/alu_pipelined.sv
// alu_pipelined: registered ALU with flags, valid/ready handshake and iterative MUL/MULHU
module alu_pipelined
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rstN,
  alu_pipelined_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  state_e             state_q, state_d;
  opcode_e            op;
  logic [WIDTH-1:0]   a, b, res_q, alu_r, mul_r, out_r;
  logic [WIDTH:0]     add_w, sub_w;
  logic [SHAMT_W-1:0] shamt;
  logic [2*WIDTH-1:0] prod;
  logic               ov_q, z_q, n_q, c_q, v_q, hi_q;
  logic               alu_c, alu_v, out_c, out_v;
  logic               free, accept, is_mul, load_alu, mul_step, mul_fin, mul_done;
  assign op    = opcode_e'(bus.operation);
  assign a     = bus.operandA;
  assign b     = bus.operandB;
  assign shamt = b[SHAMT_W-1:0];
  assign is_mul = op == MUL || op == MULHU;
  // single-cycle datapath: result plus carry/overflow for ADD and SUB only
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    alu_r = a;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      AND:      alu_r = a & b;
      OR:       alu_r = a | b;
      XOR:      alu_r = a ^ b;
      SLL, SLA: alu_r = a << shamt;
      SRL:      alu_r = a >> shamt;
      SRA:      alu_r = $signed(a) >>> shamt;
      SLT:      alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU:     alu_r = {{(WIDTH-1){1'b0}}, a < b};
      default:  alu_r = a;
    endcase
  end
  mul_iterative #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rstN(rstN), .start(accept && is_mul), .step(mul_step),
    .a(a), .b(b), .done(mul_done), .product(prod)
  );
  assign mul_r = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  assign out_r = mul_fin ? mul_r : alu_r;
  assign out_c = !mul_fin && alu_c;
  assign out_v = !mul_fin && alu_v;
  // state register
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state_q <= IDLE;
    else state_q <= state_d;
  // next state: enter MULRUN on a multiply accept, leave once the final step can be written
  always_comb
    state_d = state_q == IDLE ? (accept && is_mul ? MULRUN : IDLE) : (mul_done && free ? IDLE : MULRUN);
  // handshake and multiplier control
  always_comb begin
    free     = !ov_q || bus.outReady;
    bus.inReady = state_q == IDLE && free;
    accept   = bus.inValid && bus.inReady;
    load_alu = accept && !is_mul;
    mul_fin  = state_q == MULRUN && mul_done && free;
    mul_step = state_q == MULRUN && (!mul_done || free);
  end
  // output register: load on completion, otherwise hold until the consumer takes it
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      ov_q  <= 1'b0;
      res_q <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      if (accept) hi_q <= op == MULHU;
      if (load_alu || mul_fin) begin
        ov_q  <= 1'b1;
        res_q <= out_r;
        z_q   <= out_r == '0;
        n_q   <= out_r[WIDTH-1];
        c_q   <= out_c;
        v_q   <= out_v;
      end else if (bus.outReady) ov_q <= 1'b0;
    end
  assign bus.outValid     = ov_q;
  assign bus.result       = res_q;
  assign bus.zeroFlag     = z_q;
  assign bus.negativeFlag = n_q;
  assign bus.carryFlag    = c_q;
  assign bus.overflowFlag = v_q;
  assign bus.busy         = state_q == MULRUN;
endmodule

// File: tb/tb_alu_pipelined.sv
// tb_alu_pipelined: scoreboard bench for alu_pipelined at WIDTH=32
module tb_alu_pipelined;
  typedef struct packed {
    logic [31:0] r;
    logic z, n, c, v;
  } exp_t;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];
  int pop_cyc[$];
  alu_pipelined_if #(.WIDTH(32)) bus();
  alu_pipelined #(.WIDTH(32)) dut (.clk(clk), .rstN(rstN), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [35:0] obs();
    return {bus.result, bus.zeroFlag, bus.negativeFlag, bus.carryFlag, bus.overflowFlag};
  endfunction
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] w;
    logic [31:0] r;
    logic c, v;
    longint xa, xb, s;
    xa = longint'($signed(a));
    xb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    w = {32'b0, a} * {32'b0, b};
    case (op)
      4'b0000: begin
        r = a + b;
        c = ({32'b0, a} + {32'b0, b}) > 64'hffff_ffff;
        s = xa + xb;
        v = s != longint'($signed(r));
      end
      4'b1000: begin
        r = a - b;
        c = a < b;
        s = xa - xb;
        v = s != longint'($signed(r));
      end
      4'b0111: r = a & b;
      4'b0110: r = a | b;
      4'b0100: r = a ^ b;
      4'b0001, 4'b0010: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[31], r[31:1]};
      end
      4'b0011: r = {31'b0, xa < xb};
      4'b1011: r = {31'b0, a < b};
      4'b1010: r = w[31:0];
      4'b1001: r = w[63:32];
      default: r = a;
    endcase
    e.r = r;
    e.z = r == 32'b0;
    e.n = r[31];
    e.c = c;
    e.v = v;
    return e;
  endfunction
  // scoreboard: every output transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rstN && bus.outValid && bus.outReady) begin
      pop_cyc.push_back(cyc);
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out", {28'b0, obs()}, {28'b0, e});
      end
    end
  end
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    logic acc = 1'b0;
    bus.inValid = 1'b1;
    bus.operation = op;
    bus.operandA = a;
    bus.operandB = b;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.inReady;
      @(posedge clk);
      n++;
    end
    check("accept", 64'(acc), 64'd1);
    if (acc) sb.push_back(model(op, a, b));
    #1;
    bus.inValid = 1'b0;
    bus.operandA = $urandom;
    bus.operandB = $urandom;
    bus.operation = 4'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_mul(input string tag, input logic [35:0] e);
    int n = 0;
    int bad_busy = 0;
    int bad_rdy = 0;
    while (!bus.outValid && n < 100) begin
      if (!bus.busy) bad_busy++;
      if (bus.inReady) bad_rdy++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_busy"}, 64'(bad_busy), 64'd0);
    check({tag, "_inready"}, 64'(bad_rdy), 64'd0);
    check({tag, "_res"}, {28'b0, obs()}, {28'b0, e});
    check({tag, "_busy_clear"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] ops[14] = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h4, 4'h1, 4'h5, 4'hd, 4'h2, 4'h3, 4'hb, 4'hc, 4'he, 4'hf};
    logic [35:0] held;
    int bad;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    bus.operation = 4'h0;
    bus.operandA = '0;
    bus.operandB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outValid", 64'(bus.outValid), 64'd0);
    check("rst_result_flags", {28'b0, obs()}, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("idle_inReady", 64'(bus.inReady), 64'd1);
    send(4'b0000, 32'h7fff_ffff, 32'h1);
    check("add_ovf_latency", 64'(bus.outValid), 64'd1);
    check("add_ovf", {28'b0, obs()}, {28'b0, 32'h8000_0000, 4'b0101});
    send(4'b0000, 32'hffff_ffff, 32'h1);
    check("add_carry", {28'b0, obs()}, {28'b0, 32'h0, 4'b1010});
    send(4'b1000, 32'd3, 32'd5);
    check("sub_borrow", {28'b0, obs()}, {28'b0, 32'hffff_fffe, 4'b0110});
    send(4'b0011, 32'hffff_ffff, 32'd1);
    check("slt", {28'b0, obs()}, {28'b0, 32'h1, 4'b0000});
    send(4'b1011, 32'hffff_ffff, 32'd1);
    check("sltu", {28'b0, obs()}, {28'b0, 32'h0, 4'b1000});
    send(4'b1101, 32'h8000_0000, 32'h24);
    check("sra", {28'b0, obs()}, {28'b0, 32'hf800_0000, 4'b0100});
    drain();
    send(4'b1010, 32'h0001_0000, 32'h0001_0000);
    wait_mul("mul", {32'h0, 4'b1000});
    drain();
    send(4'b1001, 32'h0001_0000, 32'h0001_0000);
    wait_mul("mulhu", {32'h1, 4'b0000});
    drain();
    bus.outReady = 1'b0;
    send(4'b0000, 32'd5, 32'd7);
    held = obs();
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (obs() !== held || bus.inReady || !bus.outValid) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_result", {28'b0, held}, {28'b0, 32'd12, 4'b0000});
    bus.outReady = 1'b1;
    send(4'b0100, 32'hf0f0_f0f0, 32'h0ff0_0ff0);
    check("bp_xor", {28'b0, obs()}, {28'b0, 32'hff00_ff00, 4'b0100});
    drain();
    pop_cyc.delete();
    for (int k = 0; k < 8; k++) send(ops[$urandom_range(0, 13)], $urandom, $urandom);
    drain();
    check("stream_count", 64'(pop_cyc.size()), 64'd8);
    for (int k = 1; k < 8 && k < pop_cyc.size(); k++)
      check("stream_gap", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd1);
    send(4'b0000, 32'd1, 32'd1);
    drain();
    send(4'b1010, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    sb.delete();
    check("rst_mid_outValid", 64'(bus.outValid), 64'd0);
    check("rst_mid_result", 64'(bus.result), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_no_partial", 64'(bus.outValid), 64'd0);
    send(4'b0000, 32'd100, 32'd23);
    check("post_rst_add", {28'b0, obs()}, {28'b0, 32'd123, 4'b0000});
    drain();
    check("sb_final", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
